pmem_arbiter: RTL and testbench

//  Shares the single physical-memory port between two requesters: L2 line-fill reads and

---
 rtl/pmem_arbiter.sv | 127 ++++++++++++
 tb/tb_pmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Two-way arbiter sharing the physical-memory port between L2 line-fill reads and EWB
// write-backs, one whole-line transaction at a time, write-first on address match.
module pmem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned OFF_W      = 4,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_ack,
    output logic [DATA_W-1:0]         rd_rdata,

    input  logic                      wb_req,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_wdata,
    output logic                      wb_ack,

    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [ADDR_W+OFF_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]         pmem_wdata,
    input  logic [DATA_W-1:0]         pmem_rdata,
    input  logic                      pmem_resp,

    output logic                      arb_busy
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StDoneR,
        StDoneW
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0]  addr_lat;
    logic [DATA_W-1:0]  wdata_lat;

    logic addr_match;
    logic force_wr;
    logic grant_wr;
    logic grant_rd;

    // A matching address must go write-first so the read never returns a stale line.
    always_comb begin
        addr_match = rd_req && wb_req && (rd_addr == wb_addr);
        force_wr   = rd_req && wb_req && (starve_cnt == STARVE_LIM);
        grant_wr   = wb_req && (addr_match || force_wr || !rd_req);
        grant_rd   = rd_req && !grant_wr;
    end

    assign pmem_address = {addr_lat, {OFF_W{1'b0}}};
    assign pmem_wdata   = wdata_lat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            starve_cnt <= '0;
            addr_lat   <= '0;
            wdata_lat  <= '0;
            rd_rdata   <= '0;
            rd_ack     <= 1'b0;
            wb_ack     <= 1'b0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            arb_busy   <= 1'b0;
        end else begin
            rd_ack <= 1'b0;
            wb_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_wr) begin
                        state      <= StWrite;
                        addr_lat   <= wb_addr;
                        wdata_lat  <= wb_wdata;
                        pmem_write <= 1'b1;
                        arb_busy   <= 1'b1;
                        starve_cnt <= '0;
                    end else if (grant_rd) begin
                        state     <= StRead;
                        addr_lat  <= rd_addr;
                        pmem_read <= 1'b1;
                        arb_busy  <= 1'b1;
                        if (wb_req && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                StRead: begin
                    if (pmem_resp) begin
                        rd_rdata  <= pmem_rdata;
                        pmem_read <= 1'b0;
                        rd_ack    <= 1'b1;
                        state     <= StDoneR;
                    end
                end
                StWrite: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        wb_ack     <= 1'b1;
                        state      <= StDoneW;
                    end
                end
                StDoneR, StDoneW: begin
                    state    <= StIdle;
                    arb_busy <= 1'b0;
                end
                default: begin
                    state      <= StIdle;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    arb_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios then randomized traffic against a
// transaction-level model (grant rule, line memory, one ack per grant).
module tb_pmem_arbiter;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned OFF_W      = 4;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned STARVE_MAX = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    rd_req = 1'b0;
    logic [ADDR_W-1:0]       rd_addr = '0;
    logic                    rd_ack;
    logic [DATA_W-1:0]       rd_rdata;
    logic                    wb_req = 1'b0;
    logic [ADDR_W-1:0]       wb_addr = '0;
    logic [DATA_W-1:0]       wb_wdata = '0;
    logic                    wb_ack;
    logic                    pmem_read;
    logic                    pmem_write;
    logic [ADDR_W+OFF_W-1:0] pmem_address;
    logic [DATA_W-1:0]       pmem_wdata;
    logic [DATA_W-1:0]       pmem_rdata = '0;
    logic                    pmem_resp = 1'b0;
    logic                    arb_busy;

    always #5 clk = ~clk;

    pmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .OFF_W      (OFF_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_rdata     (rd_rdata),
        .wb_req       (wb_req),
        .wb_addr      (wb_addr),
        .wb_wdata     (wb_wdata),
        .wb_ack       (wb_ack),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .arb_busy     (arb_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] pm      [int];
    logic [DATA_W-1:0] ref_mem [int];

    int                m_starve  = 0;
    int                exp_ack   = 0;  // 0 none, 1 read owed, 2 write owed
    logic [ADDR_W-1:0] m_addr    = '0;
    logic [DATA_W-1:0] m_wdata   = '0;
    logic [DATA_W-1:0] m_rd_exp  = '0;
    logic [DATA_W-1:0] m_rd_hold = '0;
    bit                gk[$];      // grant order, 1 = write

    bit prev_rd = 1'b0;
    bit prev_wr = 1'b0;
    bit r_act = 1'b0;
    bit auto_resp = 1'b1;
    bit rand_mode = 1'b0;
    int rcnt = 0;
    int lat = 1;
    int n_grants = 0;
    int n_rd_acks = 0;
    int n_wb_acks = 0;
    int n_abandon = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] init_line(input int a);
        logic [31:0] x;
        x = 32'h9E37_79B1 * 32'(a + 1);
        return {x, ~x, x ^ 32'h5A5A_5A5A, x + 32'd7};
    endfunction

    function automatic logic [DATA_W-1:0] pm_get(input int a);
        if (pm.exists(a)) return pm[a];
        return init_line(a);
    endfunction

    function automatic logic [DATA_W-1:0] ref_get(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_line(a);
    endfunction

    // One clock: model update, checks, pmem responder, requester agents.
    task automatic step();
        logic sr, sw, srst;
        logic [ADDR_W-1:0] sra, swa;
        logic [DATA_W-1:0] swd;
        bit is_new, is_wr, exp_wr;
        int pa;
        sr = rd_req; sw = wb_req; sra = rd_addr; swa = wb_addr; swd = wb_wdata; srst = rst_n;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        if (!srst) begin
            if (exp_ack != 0) n_abandon++;
            m_starve = 0;
            exp_ack = 0;
            m_rd_hold = '0;
        end
        chk("strobe_exclusive", pmem_read && pmem_write, 0);
        is_new = (pmem_read && !prev_rd) || (pmem_write && !prev_wr);
        if (is_new) begin
            n_grants++;
            is_wr = pmem_write;
            exp_wr = (sr && sw) ? ((sra == swa) || (m_starve == STARVE_MAX)) : sw;
            chk("grant_requested", sr || sw, 1);
            chk("grant_kind", is_wr, exp_wr);
            gk.push_back(is_wr);
            if (exp_wr) begin
                m_addr = swa; m_wdata = swd; ref_mem[int'(swa)] = swd;
                m_starve = 0; exp_ack = 2;
            end else begin
                m_addr = sra; m_rd_exp = ref_get(int'(sra));
                if (sw && m_starve < STARVE_MAX) m_starve++;
                exp_ack = 1;
            end
        end
        if (pmem_read || pmem_write)
            chk("pmem_address", pmem_address, {m_addr, {OFF_W{1'b0}}});
        if (pmem_write) chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("arb_busy", arb_busy, exp_ack != 0);
        if (rd_ack) begin
            chk("rd_ack_owed", exp_ack, 1);
            chk("rd_rdata", rd_rdata, m_rd_exp);
            m_rd_hold = m_rd_exp;
            exp_ack = 0; n_rd_acks++; rd_req = 1'b0;
        end else begin
            chk("rd_rdata_hold", rd_rdata, m_rd_hold);
        end
        if (wb_ack) begin
            chk("wb_ack_owed", exp_ack, 2);
            exp_ack = 0; n_wb_acks++; wb_req = 1'b0;
        end
        prev_rd = pmem_read;
        prev_wr = pmem_write;
        if (!(pmem_read || pmem_write)) begin
            r_act = 1'b0;
        end else if (auto_resp) begin
            if (!r_act) begin
                r_act = 1'b1;
                rcnt = rand_mode ? int'($urandom_range(0, 3)) : lat;
            end
            if (rcnt == 0) begin
                pmem_resp = 1'b1;
                pa = int'(pmem_address[ADDR_W+OFF_W-1:OFF_W]);
                if (pmem_read) pmem_rdata = pm_get(pa);
                else pm[pa] = pmem_wdata;
            end else begin
                rcnt--;
            end
        end
        if (!pmem_resp) pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (rand_mode) begin
            if (!rd_req && !rd_ack && $urandom_range(0, 2) == 0) begin
                rd_req = 1'b1; rd_addr = 12'($urandom_range(0, 3));
            end
            if (!wb_req && !wb_ack && $urandom_range(0, 3) == 0) begin
                wb_req = 1'b1; wb_addr = 12'($urandom_range(0, 3));
                wb_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    task automatic wait_ack(input bit wb, input int maxc, output int n);
        bit got;
        n = 0;
        do begin
            step();
            n++;
            got = wb ? wb_ack : rd_ack;
        end while (!got && n < maxc);
        chk(wb ? "wb_ack_timeout" : "rd_ack_timeout", got, 1);
    endtask

    localparam logic [DATA_W-1:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DATA_W-1:0] D3 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam logic [DATA_W-1:0] D4 = 128'h4444_5555_6666_7777_8888_9999_AAAA_BBBB;

    initial begin
        int n, k, g0, r0, w0, reads_first;
        bit seen_w;

        repeat (3) step();
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_wb_ack", wb_ack, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_rd_rdata", rd_rdata, 0);
        chk("rst_arb_busy", arb_busy, 0);
        rst_n = 1'b1;
        step();

        // 1: lone read, pmem answers 3 cycles after the strobe
        lat = 3; rd_req = 1'b1; rd_addr = 12'h0A5;
        step();
        chk("t1_strobe", pmem_read, 1);
        chk("t1_addr", pmem_address, 16'h0A50);
        chk("t1_busy", arb_busy, 1);
        wait_ack(1'b0, 20, k);
        n = 1 + k;
        chk("t1_latency", n, 5);
        chk("t1_rdata", rd_rdata, init_line(12'h0A5));
        step();
        chk("t1_ack_pulse", rd_ack, 0);
        chk("t1_idle", arb_busy, 0);

        // 2: simultaneous, different lines -> read then write
        lat = 1; g0 = gk.size(); w0 = n_wb_acks;
        rd_req = 1'b1; rd_addr = 12'h100;
        wb_req = 1'b1; wb_addr = 12'h200; wb_wdata = D2;
        wait_ack(1'b0, 20, k);
        for (int i = 0; i < 20 && !pmem_write; i++) step();
        chk("t2_wdata", pmem_wdata, D2);
        wb_wdata = ~D2; wb_addr = 12'hFFF;
        wait_ack(1'b1, 20, k);
        repeat (3) step();
        chk("t2_grants", gk.size() - g0, 2);
        chk("t2_first_read", gk[g0], 0);
        chk("t2_then_write", gk[g0+1], 1);
        chk("t2_one_wb_ack", n_wb_acks - w0, 1);

        // 3: same line -> write first, read returns the new data
        g0 = gk.size();
        rd_req = 1'b1; rd_addr = 12'h3C0;
        wb_req = 1'b1; wb_addr = 12'h3C0; wb_wdata = D3;
        wait_ack(1'b1, 20, k);
        wait_ack(1'b0, 20, k);
        chk("t3_rdata", rd_rdata, D3);
        chk("t3_first_write", gk[g0], 1);
        chk("t3_then_read", gk[g0+1], 0);

        // 4: write starved by back-to-back reads
        step();
        g0 = gk.size(); w0 = n_wb_acks;
        wb_req = 1'b1; wb_addr = 12'h050; wb_wdata = D4;
        rd_req = 1'b1; rd_addr = 12'h060;
        for (int i = 0; i < 200 && n_wb_acks == w0; i++) begin
            step();
            if (n_wb_acks == w0 && !rd_req && !rd_ack) begin
                rd_req = 1'b1; rd_addr = rd_addr + 12'd1;
            end
        end
        if (rd_req) wait_ack(1'b0, 20, k);
        reads_first = 0; seen_w = 1'b0;
        for (int i = g0; i < gk.size(); i++) begin
            if (gk[i]) seen_w = 1'b1;
            else if (!seen_w) reads_first++;
        end
        chk("t4_reads_before_write", reads_first, STARVE_MAX);
        chk("t4_write_done", n_wb_acks - w0, 1);
        step();
        g0 = gk.size();
        rd_req = 1'b1; rd_addr = 12'h070;
        wb_req = 1'b1; wb_addr = 12'h080; wb_wdata = D2;
        wait_ack(1'b1, 30, k);
        chk("t4_starve_cleared", gk[g0], 0);

        // 5: reset in the middle of a write, late pmem_resp ignored
        step();
        auto_resp = 1'b0; w0 = n_wb_acks;
        wb_req = 1'b1; wb_addr = 12'h0AA; wb_wdata = D4;
        for (int i = 0; i < 10 && !pmem_write; i++) step();
        chk("t5_write_started", pmem_write, 1);
        step();
        rst_n = 1'b0; wb_req = 1'b0;
        step();
        chk("t5_rst_pmem_write", pmem_write, 0);
        chk("t5_rst_pmem_read", pmem_read, 0);
        chk("t5_rst_wb_ack", wb_ack, 0);
        chk("t5_rst_rd_ack", rd_ack, 0);
        chk("t5_rst_busy", arb_busy, 0);
        chk("t5_rst_address", pmem_address, 0);
        chk("t5_rst_wdata", pmem_wdata, 0);
        chk("t5_rst_rdata", rd_rdata, 0);
        rst_n = 1'b1; pmem_resp = 1'b1;
        repeat (3) step();
        chk("t5_no_wb_ack", n_wb_acks - w0, 0);
        chk("t5_still_idle", arb_busy, 0);
        auto_resp = 1'b1;

        // 6: request dropped and address changed right after grant
        lat = 2; r0 = n_rd_acks;
        rd_req = 1'b1; rd_addr = 12'h1B3;
        step();
        chk("t6_granted", pmem_read, 1);
        rd_req = 1'b0; rd_addr = 12'h2C4;
        step();
        chk("t6_addr_held", pmem_address, 16'h1B30);
        wait_ack(1'b0, 20, k);
        chk("t6_rdata", rd_rdata, init_line(12'h1B3));
        repeat (3) step();
        chk("t6_one_ack", n_rd_acks - r0, 1);

        // Randomized traffic on a few lines so matches and starvation occur
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        for (int i = 0; i < 100 && (rd_req || wb_req || arb_busy); i++) step();
        chk("drain_done", rd_req || wb_req || arb_busy, 0);
        chk("ack_per_grant", n_rd_acks + n_wb_acks + n_abandon, n_grants);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
